// File: rtl/digit_scan_driver.sv
// Multiplexed BCD digit scanner feeding one shared seven-segment decoder.
// Value updates land only at frame boundaries; adds leading-zero blanking and per-digit blink.
module digit_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [3:0]              digit_num,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]                cnt;
  logic [IW-1:0]                idx;
  logic [BW-1:0]                fcnt;
  logic                         blink_phase;
  logic                         pend;
  logic [NUM_DIGITS-1:0][3:0]   pending;
  logic [NUM_DIGITS-1:0][3:0]   disp;
  logic [NUM_DIGITS-1:0]        zero_run;
  logic                         slot_tick, frame_tick, blank;
  logic [3:0]                   cur;
  logic [NUM_DIGITS-1:0]        an_n;

  assign slot_tick  = (cnt == CW'(REFRESH_DIV-1));
  assign frame_tick = slot_tick && (idx == IW'(NUM_DIGITS-1));

  // zero_run[i]: digit i and every digit above it are zero
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_zr
    assign zero_run[i] = (disp[NUM_DIGITS-1:i] == '0);
  end

  always_comb begin
    cur   = disp[idx];
    blank = (blank_lz && zero_run[idx] && (idx != '0)) ||
            (blink_phase && blink_mask[idx]);
    an_n  = '1;
    if (!blank) an_n[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      pend        <= 1'b0;
      pending     <= '0;
      disp        <= '0;
      an          <= '1;
      digit_num   <= 4'hF;
      frame_start <= 1'b0;
    end else begin
      cnt <= slot_tick ? '0 : cnt + CW'(1);
      if (slot_tick)
        idx <= (idx == IW'(NUM_DIGITS-1)) ? '0 : idx + IW'(1);

      // A load coinciding with the frame boundary bypasses the pending stage
      if (frame_tick) begin
        if (load)      disp <= digits_in;
        else if (pend) disp <= pending;
        pend <= 1'b0;
        if (fcnt == BW'(BLINK_FRAMES-1)) begin
          fcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          fcnt <= fcnt + BW'(1);
        end
      end else if (load) begin
        pending <= digits_in;
        pend    <= 1'b1;
      end

      an          <= an_n;
      digit_num   <= blank ? 4'hF : cur;
      frame_start <= (idx == '0) && (cnt == '0);
    end
  end

endmodule

// File: tb/tb_digit_scan_driver.sv
// Bench for digit_scan_driver: per-cycle scoreboard plus per-scenario frame checks.
module tb_digit_scan_driver;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BF = 2;

  typedef struct packed {
    logic [N-1:0] an;
    logic [3:0]   num;
    logic         fs;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [4*N-1:0]  digits_in = '0;
  logic            load = 1'b0;
  logic            blank_lz = 1'b0;
  logic [N-1:0]    blink_mask = '0;
  logic [3:0]      digit_num;
  logic [N-1:0]    an;
  logic            frame_start;

  int checks = 0;
  int errs   = 0;

  digit_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .load(load), .blank_lz(blank_lz),
    .blink_mask(blink_mask), .digit_num(digit_num), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  localparam logic [3:0][3:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Reference model: expectations pushed at the active edge, popped at the next negedge
  task automatic scoreboard();
    exp_t q[$];
    exp_t e;
    logic [15:0] md, mpd;
    bit mp, mph, lz, bl, ft;
    int mc, mi, mf;
    md = '0; mpd = '0; mp = 0; mph = 0; mc = 0; mi = 0; mf = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        md = '0; mpd = '0; mp = 0; mph = 0; mc = 0; mi = 0; mf = 0;
        q.push_back('{an: 4'b1111, num: 4'hF, fs: 1'b0});
      end else begin
        lz = blank_lz && (mi > 0) && ((md >> (4*mi)) == 16'h0);
        bl = mph && blink_mask[mi];
        e.fs = (mi == 0) && (mc == 0);
        if (lz || bl) begin
          e.an = 4'b1111; e.num = 4'hF;
        end else begin
          e.an = ~(4'b0001 << mi); e.num = md[4*mi +: 4];
        end
        q.push_back(e);
        ft = (mc == RD-1) && (mi == N-1);
        if (ft) begin
          if (load) md = digits_in;
          else if (mp) md = mpd;
          mp = 0;
          if (mf == BF-1) begin mf = 0; mph = !mph; end
          else mf++;
        end else if (load) begin
          mpd = digits_in; mp = 1;
        end
        if (mc == RD-1) begin mc = 0; mi = (mi + 1) % N; end
        else mc++;
      end
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({an, digit_num, frame_start} !== e) begin
        errs++;
        $display("FAIL scoreboard t=%0t got an=%b num=%h fs=%b, expected an=%b num=%h fs=%b",
                 $time, an, digit_num, frame_start, e.an, e.num, e.fs);
      end
    end
  endtask

  task automatic wait_fs();
    int k = 0;
    do begin @(negedge clk); k++; end while (frame_start !== 1'b1 && k < 40);
    checks++;
    if (frame_start !== 1'b1) begin
      errs++;
      $display("FAIL frame_start_timeout got=%b expected=1", frame_start);
    end
  endtask

  // Returns with the bench at the first cycle of slot 3 of the captured frame
  task automatic capture_frame(output logic [3:0][3:0] a, output logic [3:0][3:0] n);
    wait_fs();
    a[0] = an; n[0] = digit_num;
    for (int s = 1; s < 4; s++) begin
      repeat (4) @(negedge clk);
      a[s] = an; n[s] = digit_num;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    digits_in = v; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (an !== 4'b1111 || digit_num !== 4'hF || frame_start !== 1'b0) begin
      errs++;
      $display("FAIL reset_outputs got an=%b num=%h fs=%b expected an=1111 num=f fs=0",
               an, digit_num, frame_start);
    end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    logic [3:0][3:0] a, n;
    int pulses = 0;
    capture_frame(a, n);
    checks++;
    if (a !== AN_ALL || n !== 16'h0000) begin
      errs++;
      $display("FAIL free_run got an=%h num=%h expected an=%h num=0000", a, n, AN_ALL);
    end
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (frame_start === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 2) begin
      errs++;
      $display("FAIL frame_start_rate got=%0d expected=2", pulses);
    end
  endtask

  task automatic test_midframe_load();
    logic [3:0][3:0] a, n;
    wait_fs();
    repeat (8) @(negedge clk);
    checks++;
    if (an !== 4'b1011 || digit_num !== 4'h0) begin
      errs++;
      $display("FAIL midframe_slot2 got an=%b num=%h expected an=1011 num=0", an, digit_num);
    end
    do_load(16'h1234);
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 4'b0111 || digit_num !== 4'h0) begin
      errs++;
      $display("FAIL midframe_slot3 got an=%b num=%h expected an=0111 num=0", an, digit_num);
    end
    capture_frame(a, n);
    checks++;
    if (a !== AN_ALL || n !== 16'h1234) begin
      errs++;
      $display("FAIL midframe_next got an=%h num=%h expected an=%h num=1234", a, n, AN_ALL);
    end
  endtask

  task automatic test_lz_blank();
    logic [15:0] vals [4] = '{16'h0042, 16'h0000, 16'h00A0, 16'h0302};
    logic [15:0] en   [4] = '{16'hFF42, 16'hFFF0, 16'hFFA0, 16'hF302};
    logic [15:0] ea   [4] = '{16'hFFDE, 16'hFFFE, 16'hFFDE, 16'hFBDE};
    logic [3:0][3:0] a, n;
    blank_lz = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_load(vals[k]);
      capture_frame(a, n);
      checks++;
      if (a !== ea[k] || n !== en[k]) begin
        errs++;
        $display("FAIL lz_blank val=%h got an=%h num=%h expected an=%h num=%h",
                 vals[k], a, n, ea[k], en[k]);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_blink();
    logic [3:0][3:0] a, n;
    bit b [6];
    do_load(16'h5678);
    capture_frame(a, n);
    blink_mask = 4'b0001;
    for (int f = 0; f < 6; f++) begin
      capture_frame(a, n);
      b[f] = (a[0] === 4'b1111);
      checks++;
      if (a[3:1] !== AN_ALL[3:1] || n[3:1] !== 12'h567 ||
          (b[f] ? (n[0] !== 4'hF) : (a[0] !== 4'b1110 || n[0] !== 4'h8))) begin
        errs++;
        $display("FAIL blink_frame f=%0d got an=%h num=%h", f, a, n);
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (b[k] == b[k+2]) begin
        errs++;
        $display("FAIL blink_period f=%0d got blank=%0d expected blank=%0d two frames on",
                 k, b[k+2], !b[k]);
      end
    end
    blink_mask = '0;
  endtask

  task automatic test_back_to_back();
    logic [3:0][3:0] a, n;
    wait_fs();
    do_load(16'h1111);
    repeat (13) @(negedge clk);
    do_load(16'h9999);
    for (int f = 0; f < 2; f++) begin
      capture_frame(a, n);
      checks++;
      if (a !== AN_ALL || n !== 16'h9999) begin
        errs++;
        $display("FAIL frame_tick_load f=%0d got an=%h num=%h expected num=9999", f, a, n);
      end
    end
  endtask

  task automatic test_reset_abandon();
    logic [3:0][3:0] a, n;
    digits_in = 16'hABCD; load = 1'b1;
    @(negedge clk);
    load = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (an !== 4'b1111 || digit_num !== 4'hF || frame_start !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid got an=%b num=%h fs=%b expected an=1111 num=f fs=0",
               an, digit_num, frame_start);
    end
    rst = 1'b0;
    capture_frame(a, n);
    checks++;
    if (a !== AN_ALL || n !== 16'h0000) begin
      errs++;
      $display("FAIL reset_abandon got an=%h num=%h expected num=0000", a, n);
    end
  endtask

  initial begin
    fork
      scoreboard();
      begin
        test_reset();
        test_free_run();
        test_midframe_load();
        test_lz_blank();
        test_blink();
        test_back_to_back();
        test_reset_abandon();
        repeat (4) @(negedge clk);
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
